// File: rtl/npu_inst_sequencer.sv
// NPU program sequencer: fetches 128-bit instructions from on-chip SRAM, dispatches commands to
// the compute engine over valid/ready and posts a completion status byte for software to poll.
module npu_inst_sequencer #(
  parameter int unsigned INST_AW   = 9,
  parameter int unsigned INST_DW   = 128,
  parameter int unsigned DONE_AW   = 9,
  parameter int unsigned DONE_ADDR = 0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INST_AW-1:0] start_pc,
  output logic               busy,
  output logic               err,
  output logic [15:0]        inst_count,
  output logic [INST_AW-1:0] inst_address,
  output logic               inst_chipselect,
  output logic               inst_clken,
  output logic               inst_write,
  input  logic [INST_DW-1:0] inst_readdata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [7:0]         cmd_opcode,
  output logic [INST_DW-9:0] cmd_payload,
  output logic [DONE_AW-1:0] done_address,
  output logic               done_chipselect,
  output logic               done_clken,
  output logic               done_write,
  output logic [7:0]         done_writedata
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StWait,
    StDecode,
    StIssue,
    StPost
  } state_e;

  localparam logic [INST_AW-1:0] PcMax   = '1;
  localparam logic [7:0]         OpHalt  = 8'h00;
  localparam logic [7:0]         OpNop   = 8'hFF;
  localparam logic [7:0]         StatRun = 8'h00;
  localparam logic [7:0]         StatOk  = 8'h01;
  localparam logic [7:0]         StatOvr = 8'h02;

  state_e               state_q, state_d;
  logic [INST_AW-1:0]   pc_q, pc_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [15:0]          count_q, count_d;
  logic                 inst_cs_q, inst_cs_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [INST_DW-9:0]   payload_q, payload_d;
  logic                 done_cs_q, done_cs_d;
  logic [7:0]           status_q, status_d;

  logic [7:0]           rd_opcode;
  logic                 pc_at_max;

  assign rd_opcode = inst_readdata[INST_DW-1 -: 8];
  assign pc_at_max = (pc_q == PcMax);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    busy_d      = busy_q;
    err_d       = err_q;
    count_d     = count_q;
    cmd_valid_d = cmd_valid_q;
    opcode_d    = opcode_q;
    payload_d   = payload_q;
    status_d    = status_q;
    // Chip selects are single-cycle strobes aligned with the state that owns them.
    inst_cs_d   = 1'b0;
    done_cs_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StClear;
          pc_d      = start_pc;
          count_d   = 16'd0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          done_cs_d = 1'b1;
          status_d  = StatRun;
        end
      end
      StClear: begin
        state_d   = StFetch;
        inst_cs_d = 1'b1;
      end
      StFetch: begin
        state_d = (RD_LAT == 2) ? StWait : StDecode;
      end
      StWait: begin
        state_d = StDecode;
      end
      StDecode: begin
        opcode_d  = rd_opcode;
        payload_d = inst_readdata[INST_DW-9:0];
        if (rd_opcode == OpHalt) begin
          state_d   = StPost;
          done_cs_d = 1'b1;
          status_d  = StatOk;
        end else if (rd_opcode == OpNop) begin
          if (pc_at_max) begin
            state_d   = StPost;
            err_d     = 1'b1;
            done_cs_d = 1'b1;
            status_d  = StatOvr;
          end else begin
            state_d   = StFetch;
            pc_d      = pc_q + INST_AW'(1);
            inst_cs_d = 1'b1;
          end
        end else begin
          state_d     = StIssue;
          cmd_valid_d = 1'b1;
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          // The last SRAM word is a dead end: flag overrun rather than wrap to address 0.
          if (pc_at_max) begin
            state_d   = StPost;
            err_d     = 1'b1;
            done_cs_d = 1'b1;
            status_d  = StatOvr;
          end else begin
            state_d   = StFetch;
            pc_d      = pc_q + INST_AW'(1);
            inst_cs_d = 1'b1;
          end
        end
      end
      StPost: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= 16'd0;
      inst_cs_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      opcode_q    <= 8'd0;
      payload_q   <= '0;
      done_cs_q   <= 1'b0;
      status_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      count_q     <= count_d;
      inst_cs_q   <= inst_cs_d;
      cmd_valid_q <= cmd_valid_d;
      opcode_q    <= opcode_d;
      payload_q   <= payload_d;
      done_cs_q   <= done_cs_d;
      status_q    <= status_d;
    end
  end

  assign busy            = busy_q;
  assign err             = err_q;
  assign inst_count      = count_q;
  assign inst_address    = pc_q;
  assign inst_chipselect = inst_cs_q;
  assign inst_clken      = 1'b1;
  assign inst_write      = 1'b0;
  assign cmd_valid       = cmd_valid_q;
  assign cmd_opcode      = opcode_q;
  assign cmd_payload     = payload_q;
  assign done_address    = DONE_AW'(DONE_ADDR);
  assign done_chipselect = done_cs_q;
  assign done_clken      = 1'b1;
  assign done_write      = done_cs_q;
  assign done_writedata  = status_q;

endmodule

// File: tb/tb_npu_inst_sequencer.sv
// Bench for npu_inst_sequencer: a 1-cycle and a 2-cycle read-latency instance share one SRAM image;
// expected commands and status writes are queued at stimulus time and retired by a monitor.
module tb_npu_inst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start = 1'b0, start2 = 1'b0;
  logic [8:0]   start_pc = '0, start_pc2 = '0;
  logic         cmd_ready = 1'b1, cmd_ready2 = 1'b1;

  logic         busy, err, inst_cs, inst_clken, inst_write, cmd_valid;
  logic         done_cs, done_clken, done_write;
  logic [15:0]  inst_count;
  logic [8:0]   inst_address, done_address;
  logic [7:0]   cmd_opcode, done_writedata;
  logic [119:0] cmd_payload;

  logic         busy2, err2, inst_cs2, inst_clken2, inst_write2, cmd_valid2;
  logic         done_cs2, done_clken2, done_write2;
  logic [15:0]  inst_count2;
  logic [8:0]   inst_address2, done_address2;
  logic [7:0]   cmd_opcode2, done_writedata2;
  logic [119:0] cmd_payload2;

  logic [127:0] mem [0:511];
  logic [127:0] rd1 = '0, rd2a = '0, rd2b = '0;

  always @(posedge clk) begin
    if (inst_cs) rd1 <= mem[inst_address];
    if (inst_cs2) rd2a <= mem[inst_address2];
    rd2b <= rd2a;
  end

  npu_inst_sequencer #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .busy(busy), .err(err), .inst_count(inst_count),
    .inst_address(inst_address), .inst_chipselect(inst_cs), .inst_clken(inst_clken),
    .inst_write(inst_write), .inst_readdata(rd1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_payload(cmd_payload), .done_address(done_address), .done_chipselect(done_cs),
    .done_clken(done_clken), .done_write(done_write), .done_writedata(done_writedata)
  );

  npu_inst_sequencer #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .start_pc(start_pc2),
    .busy(busy2), .err(err2), .inst_count(inst_count2),
    .inst_address(inst_address2), .inst_chipselect(inst_cs2), .inst_clken(inst_clken2),
    .inst_write(inst_write2), .inst_readdata(rd2b),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_opcode(cmd_opcode2),
    .cmd_payload(cmd_payload2), .done_address(done_address2), .done_chipselect(done_cs2),
    .done_clken(done_clken2), .done_write(done_write2), .done_writedata(done_writedata2)
  );

  typedef struct {
    logic [7:0]   op;
    logic [119:0] pl;
    int           rel;
  } cmd_t;

  typedef struct {
    logic [7:0] st;
    int         rel;
  } done_t;

  cmd_t  cq1[$], cq2[$];
  done_t dq1[$], dq2[$];
  cmd_t  c;
  done_t d;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [119:0] rnd_pl();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[119:0];
  endfunction

  function automatic cmd_t mk_cmd(input logic [7:0] op, input logic [119:0] pl, input int rel);
    cmd_t r;
    r.op = op;
    r.pl = pl;
    r.rel = rel;
    return r;
  endfunction

  function automatic done_t mk_done(input logic [7:0] st, input int rel);
    done_t r;
    r.st = st;
    r.rel = rel;
    return r;
  endfunction

  // Retires handshakes and status writes of both instances against their queues.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        total++;
        if (cq1.size() == 0) begin
          bad++;
          $display("FAIL cmd1_extra: got op=%02h at cycle %0d, required none", cmd_opcode,
                   cyc - start_cyc);
        end else begin
          c = cq1.pop_front();
          if ({cmd_opcode, cmd_payload} !== {c.op, c.pl}) begin
            bad++;
            $display("FAIL cmd1_data: got %02h/%h required %02h/%h", cmd_opcode, cmd_payload,
                     c.op, c.pl);
          end
          total++;
          if (cyc - start_cyc != c.rel) begin
            bad++;
            $display("FAIL cmd1_cycle: got %0d required %0d", cyc - start_cyc, c.rel);
          end
        end
      end
      if (done_cs) begin
        total++;
        if (dq1.size() == 0) begin
          bad++;
          $display("FAIL done1_extra: got status %02h at cycle %0d, required none",
                   done_writedata, cyc - start_cyc);
        end else begin
          d = dq1.pop_front();
          if ({done_write, done_address, done_writedata} !== {1'b1, 9'd0, d.st}) begin
            bad++;
            $display("FAIL done1_data: got we=%b a=%0d st=%02h required 1/0/%02h", done_write,
                     done_address, done_writedata, d.st);
          end
          total++;
          if (cyc - start_cyc != d.rel) begin
            bad++;
            $display("FAIL done1_cycle: got %0d required %0d", cyc - start_cyc, d.rel);
          end
        end
      end
      if (cmd_valid2 && cmd_ready2) begin
        total++;
        if (cq2.size() == 0) begin
          bad++;
          $display("FAIL cmd2_extra: got op=%02h, required none", cmd_opcode2);
        end else begin
          c = cq2.pop_front();
          if ({cmd_opcode2, cmd_payload2, cyc - start_cyc} !== {c.op, c.pl, c.rel}) begin
            bad++;
            $display("FAIL cmd2: got %02h/%h@%0d required %02h/%h@%0d", cmd_opcode2,
                     cmd_payload2, cyc - start_cyc, c.op, c.pl, c.rel);
          end
        end
      end
      if (done_cs2) begin
        total++;
        if (dq2.size() == 0) begin
          bad++;
          $display("FAIL done2_extra: got status %02h, required none", done_writedata2);
        end else begin
          d = dq2.pop_front();
          if ({done_write2, done_writedata2, cyc - start_cyc} !== {1'b1, d.st, d.rel}) begin
            bad++;
            $display("FAIL done2: got we=%b st=%02h@%0d required 1/%02h@%0d", done_write2,
                     done_writedata2, cyc - start_cyc, d.st, d.rel);
          end
        end
      end
    end
  endtask

  // Returns at the negedge of relative cycle 1 (the CLEAR cycle).
  task automatic do_start(input int which, input logic [8:0] pc);
    @(negedge clk);
    start_cyc = cyc;
    if (which == 1) begin
      start = 1'b1;
      start_pc = pc;
    end else begin
      start2 = 1'b1;
      start_pc2 = pc;
    end
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget, output int rel);
    rel = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!((which == 1) ? busy : busy2)) begin
        rel = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, err, cmd_valid, inst_cs, done_cs, done_write} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {busy, err, cmd_valid, inst_cs, done_cs, done_write});
    end
    total++;
    if ({inst_count, cmd_opcode, cmd_payload, done_writedata, inst_address} !== '0) begin
      bad++;
      $display("FAIL reset_regs: cnt=%0d op=%02h pl=%h st=%02h pc=%0d required all 0",
               inst_count, cmd_opcode, cmd_payload, done_writedata, inst_address);
    end
    total++;
    if ({inst_clken, inst_write, done_clken, done_address} !== {3'b101, 9'd0}) begin
      bad++;
      $display("FAIL reset_ties: got %b/%0d required 101/0",
               {inst_clken, inst_write, done_clken}, done_address);
    end
    total++;
    if ({busy2, cmd_valid2, done_cs2, inst_count2} !== '0) begin
      bad++;
      $display("FAIL reset_dut2: got busy=%b v=%b dcs=%b cnt=%0d required 0", busy2,
               cmd_valid2, done_cs2, inst_count2);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [119:0] p0, p1;
    int rel;
    p0 = rnd_pl();
    p1 = rnd_pl();
    mem[0] = {8'h01, p0};
    mem[1] = {8'h02, p1};
    mem[2] = {8'h00, rnd_pl()};
    cmd_ready = 1'b1;
    cq1.push_back(mk_cmd(8'h01, p0, 4));
    cq1.push_back(mk_cmd(8'h02, p1, 7));
    dq1.push_back(mk_done(8'h00, 1));
    dq1.push_back(mk_done(8'h01, 10));
    do_start(1, 9'd0);
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++;
      $display("FAIL basic_busy: got busy=%b err=%b required 1/0", busy, err);
    end
    @(negedge clk);
    total++;
    if ({inst_cs, inst_address} !== {1'b1, 9'd0}) begin
      bad++;
      $display("FAIL basic_fetch: got cs=%b a=%0d required 1/0", inst_cs, inst_address);
    end
    wait_idle(1, 40, rel);
    total++;
    if (rel != 11) begin
      bad++;
      $display("FAIL basic_idle: busy low at cycle %0d required 11", rel);
    end
    total++;
    if ({inst_count, cmd_valid} !== {16'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_count: got cnt=%0d v=%b required 2/0", inst_count, cmd_valid);
    end
    total++;
    if (cq1.size() + dq1.size() != 0) begin
      bad++;
      $display("FAIL basic_drain: got %0d outstanding required 0", cq1.size() + dq1.size());
    end
  endtask

  task automatic test_nop();
    int rel;
    mem[10] = {8'hFF, rnd_pl()};
    mem[11] = {8'hFF, rnd_pl()};
    mem[12] = {8'h00, rnd_pl()};
    dq1.push_back(mk_done(8'h00, 1));
    dq1.push_back(mk_done(8'h01, 8));
    do_start(1, 9'd10);
    repeat (5) @(negedge clk);
    total++;
    if ({inst_cs, inst_address} !== {1'b1, 9'd12}) begin
      bad++;
      $display("FAIL nop_fetch: got cs=%b a=%0d at cycle 6 required 1/12", inst_cs,
               inst_address);
    end
    wait_idle(1, 40, rel);
    total++;
    if (rel != 9) begin
      bad++;
      $display("FAIL nop_idle: busy low at cycle %0d required 9", rel);
    end
    total++;
    if (inst_count !== 16'd0 || dq1.size() != 0) begin
      bad++;
      $display("FAIL nop_count: got cnt=%0d pending=%0d required 0/0", inst_count, dq1.size());
    end
  endtask

  task automatic test_stall();
    logic [119:0] p;
    int rel;
    p = rnd_pl();
    mem[20] = {8'h05, p};
    mem[21] = {8'h00, rnd_pl()};
    cmd_ready = 1'b0;
    cq1.push_back(mk_cmd(8'h05, p, 14));
    dq1.push_back(mk_done(8'h00, 1));
    dq1.push_back(mk_done(8'h01, 17));
    do_start(1, 9'd20);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({cmd_valid, cmd_opcode, cmd_payload, inst_address} !== {1'b1, 8'h05, p, 9'd20}) begin
        bad++;
        $display("FAIL stall_hold: cycle %0d v=%b op=%02h a=%0d required 1/05/20", i + 4,
                 cmd_valid, cmd_opcode, inst_address);
      end
      if (i < 9) @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    wait_idle(1, 40, rel);
    total++;
    if (rel != 18) begin
      bad++;
      $display("FAIL stall_idle: busy low at cycle %0d required 18", rel);
    end
    total++;
    if ({inst_count, cmd_valid} !== {16'd1, 1'b0} || cq1.size() != 0) begin
      bad++;
      $display("FAIL stall_count: got cnt=%0d v=%b pending=%0d required 1/0/0", inst_count,
               cmd_valid, cq1.size());
    end
  endtask

  task automatic test_overrun();
    logic [119:0] p;
    int rel;
    logic saw_zero;
    p = rnd_pl();
    mem[511] = {8'h03, p};
    cmd_ready = 1'b1;
    cq1.push_back(mk_cmd(8'h03, p, 4));
    dq1.push_back(mk_done(8'h00, 1));
    dq1.push_back(mk_done(8'h02, 5));
    do_start(1, 9'd511);
    saw_zero = (inst_address == 9'd0);
    rel = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_address == 9'd0) saw_zero = 1'b1;
      if (!busy) begin
        rel = cyc - start_cyc;
        break;
      end
    end
    total++;
    if (rel != 6) begin
      bad++;
      $display("FAIL ovr_idle: busy low at cycle %0d required 6", rel);
    end
    total++;
    if (saw_zero !== 1'b0) begin
      bad++;
      $display("FAIL ovr_wrap: inst_address reached 0, required never");
    end
    total++;
    if ({err, inst_count, inst_address} !== {1'b1, 16'd1, 9'd511}) begin
      bad++;
      $display("FAIL ovr_state: got err=%b cnt=%0d a=%0d required 1/1/511", err, inst_count,
               inst_address);
    end
  endtask

  task automatic test_reset_mid();
    mem[30] = {8'h07, rnd_pl()};
    mem[31] = {8'h00, rnd_pl()};
    cmd_ready = 1'b0;
    dq1.push_back(mk_done(8'h00, 1));
    do_start(1, 9'd30);
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++;
      $display("FAIL mid_start: got busy=%b err=%b required 1/0", busy, err);
    end
    @(negedge clk);
    start = 1'b1;
    start_pc = 9'd100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_valid, busy, inst_address} !== {2'b11, 9'd30}) begin
      bad++;
      $display("FAIL mid_ignore: got v=%b busy=%b a=%0d required 1/1/30", cmd_valid, busy,
               inst_address);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_valid, busy, done_cs, inst_count, cmd_opcode} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b busy=%b dcs=%b cnt=%0d op=%02h required 0", cmd_valid,
               busy, done_cs, inst_count, cmd_opcode);
    end
    cmd_ready = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b0 || dq1.size() != 0) begin
      bad++;
      $display("FAIL mid_quiet: got busy=%b pending=%0d required 0/0", busy, dq1.size());
    end
  endtask

  task automatic test_rdlat2();
    logic [119:0] p0, p1;
    int rel;
    p0 = rnd_pl();
    p1 = rnd_pl();
    mem[0] = {8'h01, p0};
    mem[1] = {8'h02, p1};
    mem[2] = {8'h00, rnd_pl()};
    cmd_ready2 = 1'b1;
    cq2.push_back(mk_cmd(8'h01, p0, 5));
    cq2.push_back(mk_cmd(8'h02, p1, 9));
    dq2.push_back(mk_done(8'h00, 1));
    dq2.push_back(mk_done(8'h01, 13));
    do_start(2, 9'd0);
    wait_idle(2, 40, rel);
    total++;
    if (rel != 14) begin
      bad++;
      $display("FAIL rd2_idle: busy low at cycle %0d required 14", rel);
    end
    total++;
    if (inst_count2 !== 16'd2 || cq2.size() + dq2.size() != 0) begin
      bad++;
      $display("FAIL rd2_count: got cnt=%0d pending=%0d required 2/0", inst_count2,
               cq2.size() + dq2.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_nop();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_rdlat2();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
